nms_window_3x3: RTL and testbench
=================================

Name: nms_window_3x3

Overview:
- Parametrised successor to the fixed 320-pixel NMS line buffer in the Canny pipeline.
- Accepts a raster stream of gradient magnitude plus quantised angle, and emits a full 3x3 magnitude window with the centre pixel's angle.
- Adds a valid qualifier, start-of-frame resync, row/column tracking, zero-padded borders and a border flag.
- Sits between the gradient/angle stage and the non-maximum-suppression comparator.

Parameters:
- DATA_W, 20, magnitude width in bits.
- ANG_W, 2, angle code width in bits.
- LINE_W, 320, pixels per line (>=3).
- LINE_H, 240, lines per frame (>=3).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  qualifies pix_in/ang_in/in_sof this cycle.
- in_sof  in  1  marks the pixel at (row 0, col 0); sampled only when in_valid=1.
- pix_in  in  DATA_W  magnitude.
- ang_in  in  ANG_W  angle code.
- out_valid  out  1  window outputs valid this cycle.
- win_t0, win_t1, win_t2  out  DATA_W each  top row, left/centre/right.
- win_m0, win_m1, win_m2  out  DATA_W each  middle row; win_m1 is the centre pixel.
- win_b0, win_b1, win_b2  out  DATA_W each  bottom row.
- out_ang  out  ANG_W  angle of the centre pixel.
- out_border  out  1  centre lies on row 0 or col 0 (padding was applied).
- out_row  out  $clog2(LINE_H)  centre row.
- out_col  out  $clog2(LINE_W)  centre column.

Behaviour:
- Reset (async, rst=1): all outputs 0, counters 0, column shift registers 0. Line memories need not be cleared; their stale contents are never visible because of padding masks.
- Accepted pixel: a cycle with in_valid=1, at coordinates (r,c) given by internal counters. A cycle with in_valid=0 changes no state and drives out_valid=0 on the next cycle; the window outputs hold their last value.
- Counters:
  - c increments per accepted pixel.
  - At c=LINE_W-1, c wraps to 0 and r increments.
  - At r=LINE_H-1, c=LINE_W-1, both wrap to 0.
- in_sof=1 with in_valid=1:
  - The pixel is treated as (0,0) regardless of the counters; the next pixel is (0,1).
  - Column shift registers are cleared.
  - Allowed mid-frame as a resync; no error flag.
- Storage:
  - Two magnitude line memories of LINE_W entries: row r-1 and row r-2.
  - One angle line memory of LINE_W entries: row r-1.
- On each accepted (r,c):
  - Read mag[r-1][c], mag[r-2][c] and ang[r-1][c].
  - Write pix_in into row r-1 memory at c.
  - Move the old row r-1 entry into the row r-2 memory at c.
  - Write ang_in into the angle memory at c.
- Column shift: three 3-deep column registers (top/mid/bottom) shift left and take the new column {mag[r-2][c], mag[r-1][c], pix_in}. The angle is delayed one column.
- Output timing (latency 1 cycle after acceptance):
  - out_valid=1 iff the accepted pixel had r>=1 and c>=1.
  - Centre = (r-1, c-1). out_row=r-1, out_col=c-1.
  - Columns: right = column c, centre = column c-1, left = column c-2.
  - Rows: top = r-2, middle = r-1, bottom = r.
- Padding:
  - Centre row 0: win_t0..t2 forced to 0.
  - Centre col 0: win_t0, win_m0, win_b0 forced to 0.
  - out_border = (centre row==0) | (centre col==0).
- Centres on the last row or last column are never emitted. This is by design; downstream zeroes them.
- Throughput: one window per accepted pixel, no back-pressure.
- rst asserted mid-frame: all outputs are 0 immediately; the first pixel after release is (0,0) even without in_sof.

Test Plan:
- LINE_W=4, LINE_H=3, pix=10*r+c, ang=c[1:0], continuous in_valid from reset -> first out_valid one cycle after (1,1) is accepted: T=0,0,0; M=0,0,1; B=0,10,11; out_border=1; out_row=0, out_col=0; out_ang=0.
- Same stream, accept (2,2) -> T=0,1,2; M=10,11,12; B=20,21,22; out_border=0; out_ang=1; out_row=1, out_col=1.
- Same stream with in_valid toggling 1/0 each cycle -> identical window sequence; out_valid never asserts in the cycle after in_valid=0.
- Second frame with pix=100+10*r+c -> centre (0,1) has T=0,0,0 despite stale frame-1 data; M=100,101,102.
- in_sof pulsed at frame pixel 5 -> counters resync; the next out_valid centre is (0,0) with left column 0.
- rst pulsed while out_valid=1 -> outputs 0 asynchronously; the post-reset stream reproduces scenario 1 exactly.

Source files
------------

// File: rtl/nms_window_3x3.sv
// 3x3 magnitude window generator for the Canny NMS stage: two line memories plus column
// shift registers. Rows and columns before the first are padded with zeros.
module nms_window_3x3 #(
  parameter int DATA_W = 20,
  parameter int ANG_W  = 2,
  parameter int LINE_W = 320,
  parameter int LINE_H = 240
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  input  logic                      in_sof,
  input  logic [DATA_W-1:0]         pix_in,
  input  logic [ANG_W-1:0]          ang_in,
  output logic                      out_valid,
  output logic [DATA_W-1:0]         win_t0,
  output logic [DATA_W-1:0]         win_t1,
  output logic [DATA_W-1:0]         win_t2,
  output logic [DATA_W-1:0]         win_m0,
  output logic [DATA_W-1:0]         win_m1,
  output logic [DATA_W-1:0]         win_m2,
  output logic [DATA_W-1:0]         win_b0,
  output logic [DATA_W-1:0]         win_b1,
  output logic [DATA_W-1:0]         win_b2,
  output logic [ANG_W-1:0]          out_ang,
  output logic                      out_border,
  output logic [$clog2(LINE_H)-1:0] out_row,
  output logic [$clog2(LINE_W)-1:0] out_col
);

  localparam int RW = $clog2(LINE_H);
  localparam int CW = $clog2(LINE_W);

  logic [DATA_W-1:0] mem_r1 [LINE_W];
  logic [DATA_W-1:0] mem_r2 [LINE_W];
  logic [ANG_W-1:0]  mem_ang [LINE_W];

  logic [RW-1:0]     r_reg, r_eff, r_next;
  logic [CW-1:0]     c_reg, c_eff, c_next;
  logic [CW-1:0]     wb_addr_reg;
  logic [DATA_W-1:0] rd1_reg, rd2_reg, pix_reg, rd2_src;
  logic [ANG_W-1:0]  rda_reg, ang_reg;
  logic [DATA_W-1:0] ctr_t_reg, ctr_m_reg, ctr_b_reg;
  logic [DATA_W-1:0] lft_t_reg, lft_m_reg, lft_b_reg;
  logic              valid_reg, top_pad_reg, left_pad_reg;
  logic [RW-1:0]     row_reg;
  logic [CW-1:0]     col_reg;

  // A start-of-frame pixel is placed at (0,0) regardless of the running counters.
  always_comb begin
    r_eff  = in_sof ? '0 : r_reg;
    c_eff  = in_sof ? '0 : c_reg;
    r_next = r_eff;
    c_next = c_eff + CW'(1);
    if (c_eff == CW'(LINE_W - 1)) begin
      c_next = '0;
      r_next = (r_eff == RW'(LINE_H - 1)) ? '0 : r_eff + RW'(1);
    end
  end

  // The r-1 -> r-2 move is written one accept late from the registered read, so a
  // back-to-back access to the same column takes the pending value directly.
  always_comb begin
    rd2_src = mem_r2[c_eff];
    if (wb_addr_reg == c_eff) rd2_src = rd1_reg;
  end

  always_ff @(posedge clk) begin
    if (in_valid) begin
      mem_r1[c_eff]       <= pix_in;
      mem_ang[c_eff]      <= ang_in;
      mem_r2[wb_addr_reg] <= rd1_reg;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_reg        <= '0;
      c_reg        <= '0;
      wb_addr_reg  <= '0;
      rd1_reg      <= '0;
      rd2_reg      <= '0;
      rda_reg      <= '0;
      pix_reg      <= '0;
      ctr_t_reg    <= '0;
      ctr_m_reg    <= '0;
      ctr_b_reg    <= '0;
      lft_t_reg    <= '0;
      lft_m_reg    <= '0;
      lft_b_reg    <= '0;
      ang_reg      <= '0;
      valid_reg    <= 1'b0;
      top_pad_reg  <= 1'b0;
      left_pad_reg <= 1'b0;
      row_reg      <= '0;
      col_reg      <= '0;
    end else begin
      valid_reg <= in_valid && (r_eff != '0) && (c_eff != '0);
      if (in_valid) begin
        r_reg       <= r_next;
        c_reg       <= c_next;
        wb_addr_reg <= c_eff;
        rd1_reg     <= mem_r1[c_eff];
        rd2_reg     <= rd2_src;
        rda_reg     <= mem_ang[c_eff];
        pix_reg     <= pix_in;
        if (in_sof) begin
          ctr_t_reg <= '0;
          ctr_m_reg <= '0;
          ctr_b_reg <= '0;
          lft_t_reg <= '0;
          lft_m_reg <= '0;
          lft_b_reg <= '0;
          ang_reg   <= '0;
        end else begin
          ctr_t_reg <= rd2_reg;
          ctr_m_reg <= rd1_reg;
          ctr_b_reg <= pix_reg;
          lft_t_reg <= ctr_t_reg;
          lft_m_reg <= ctr_m_reg;
          lft_b_reg <= ctr_b_reg;
          ang_reg   <= rda_reg;
        end
        top_pad_reg  <= (r_eff == RW'(1));
        left_pad_reg <= (c_eff == CW'(1));
        row_reg      <= r_eff - RW'(1);
        col_reg      <= c_eff - CW'(1);
      end
    end
  end

  // Right column comes straight from the registered reads; padding masks hide stale data.
  assign win_t2     = top_pad_reg ? '0 : rd2_reg;
  assign win_m2     = rd1_reg;
  assign win_b2     = pix_reg;
  assign win_t1     = top_pad_reg ? '0 : ctr_t_reg;
  assign win_m1     = ctr_m_reg;
  assign win_b1     = ctr_b_reg;
  assign win_t0     = (top_pad_reg || left_pad_reg) ? '0 : lft_t_reg;
  assign win_m0     = left_pad_reg ? '0 : lft_m_reg;
  assign win_b0     = left_pad_reg ? '0 : lft_b_reg;
  assign out_valid  = valid_reg;
  assign out_ang    = ang_reg;
  assign out_border = top_pad_reg | left_pad_reg;
  assign out_row    = row_reg;
  assign out_col    = col_reg;

endmodule

// File: tb/tb_nms_window_3x3.sv
// Bench for nms_window_3x3 on a 4x3 frame: directed scenarios plus random traffic,
// checked against a whole-frame image model with zero padding.
module tb_nms_window_3x3;

  localparam int W  = 4;
  localparam int H  = 3;
  localparam int DW = 20;
  localparam int AW = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_sof = 1'b0;
  logic [DW-1:0] pix_in = '0;
  logic [AW-1:0] ang_in = '0;
  logic          out_valid, out_border;
  logic [DW-1:0] win_t0, win_t1, win_t2, win_m0, win_m1, win_m2, win_b0, win_b1, win_b2;
  logic [AW-1:0] out_ang;
  logic [1:0]    out_row;
  logic [1:0]    out_col;

  nms_window_3x3 #(.DATA_W(DW), .ANG_W(AW), .LINE_W(W), .LINE_H(H)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_sof(in_sof),
    .pix_in(pix_in), .ang_in(ang_in), .out_valid(out_valid),
    .win_t0(win_t0), .win_t1(win_t1), .win_t2(win_t2),
    .win_m0(win_m0), .win_m1(win_m1), .win_m2(win_m2),
    .win_b0(win_b0), .win_b1(win_b1), .win_b2(win_b2),
    .out_ang(out_ang), .out_border(out_border), .out_row(out_row), .out_col(out_col)
  );

  always #5 clk = ~clk;

  int compared = 0;
  int mismatched = 0;

  // Reference model: the frame as a 2-D image indexed by stream coordinates.
  int            mr = 0, mc = 0;
  logic [DW-1:0] img [H][W];
  logic [AW-1:0] aimg [H][W];

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step(bit v, bit s, logic [DW-1:0] p, logic [AW-1:0] a);
    logic [DW-1:0] ew [3][3];
    logic [DW-1:0] ow [3][3];
    bit            ev = 1'b0;
    logic [AW-1:0] ea = '0;
    bit            eb = 1'b0;
    int            er = 0, ec = 0;
    in_valid = v; in_sof = s; pix_in = p; ang_in = a;
    if (v) begin
      if (s) begin mr = 0; mc = 0; end
      img[mr][mc]  = p;
      aimg[mr][mc] = a;
      ev = (mr >= 1) && (mc >= 1);
      if (ev) begin
        for (int i = 0; i < 3; i++)
          for (int j = 0; j < 3; j++)
            if ((i == 0 && mr == 1) || (j == 0 && mc == 1)) ew[i][j] = '0;
            else ew[i][j] = img[mr-2+i][mc-2+j];
        ea = aimg[mr-1][mc-1];
        eb = (mr == 1) || (mc == 1);
        er = mr - 1;
        ec = mc - 1;
      end
      mc++;
      if (mc == W) begin
        mc = 0;
        mr++;
        if (mr == H) mr = 0;
      end
    end
    @(posedge clk);
    #1;
    chk("out_valid", out_valid, ev);
    if (ev) begin
      ow[0][0] = win_t0; ow[0][1] = win_t1; ow[0][2] = win_t2;
      ow[1][0] = win_m0; ow[1][1] = win_m1; ow[1][2] = win_m2;
      ow[2][0] = win_b0; ow[2][1] = win_b1; ow[2][2] = win_b2;
      for (int i = 0; i < 3; i++)
        for (int j = 0; j < 3; j++)
          chk($sformatf("win[%0d][%0d]@(%0d,%0d)", i, j, er, ec), ow[i][j], ew[i][j]);
      chk("out_ang", out_ang, ea);
      chk("out_border", out_border, eb);
      chk("out_row", out_row, er);
      chk("out_col", out_col, ec);
    end
    $display("step v=%0d sof=%0d pix=%0d ang=%0d -> out_valid=%0d row=%0d col=%0d m1=%0d",
             v, s, p, a, out_valid, out_row, out_col, win_m1);
  endtask

  task automatic check_zero(string tag);
    chk({tag, "_valid"}, out_valid, 0);
    chk({tag, "_t2"}, win_t2, 0);
    chk({tag, "_m1"}, win_m1, 0);
    chk({tag, "_m2"}, win_m2, 0);
    chk({tag, "_b2"}, win_b2, 0);
    chk({tag, "_border"}, out_border, 0);
    chk({tag, "_rowcol"}, {out_row, out_col}, 0);
  endtask

  // Scenario 1 stream (pix = 10r+c, ang = c) with the two documented windows checked by value.
  task automatic frame_one(bit first_sof);
    for (int k = 0; k < W * H; k++) begin
      step(1'b1, first_sof && (k == 0), DW'(10 * (k / W) + (k % W)), AW'(k % W));
      if (k == 5) begin
        chk("s1_t", {win_t0, win_t1, win_t2}, 0);
        chk("s1_m0", win_m0, 0); chk("s1_m1", win_m1, 0); chk("s1_m2", win_m2, 1);
        chk("s1_b0", win_b0, 0); chk("s1_b1", win_b1, 10); chk("s1_b2", win_b2, 11);
        chk("s1_border", out_border, 1); chk("s1_ang", out_ang, 0);
        chk("s1_rc", {out_row, out_col}, 0);
      end
      if (k == 10) begin
        chk("s2_t0", win_t0, 0); chk("s2_t1", win_t1, 1); chk("s2_t2", win_t2, 2);
        chk("s2_m0", win_m0, 10); chk("s2_m1", win_m1, 11); chk("s2_m2", win_m2, 12);
        chk("s2_b0", win_b0, 20); chk("s2_b1", win_b1, 21); chk("s2_b2", win_b2, 22);
        chk("s2_border", out_border, 0); chk("s2_ang", out_ang, 1);
        chk("s2_row", out_row, 1); chk("s2_col", out_col, 1);
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #2;
    check_zero("reset");
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    frame_one(1'b0);

    // Gapped stream: every other cycle idle, same windows expected.
    for (int k = 0; k < W * H; k++) begin
      step(1'b1, k == 0, DW'(10 * (k / W) + (k % W)), AW'(k % W));
      step(1'b0, 1'b0, DW'($urandom), AW'($urandom));
    end

    // Second frame over stale memory contents: top row of centre row 0 must be padding.
    for (int k = 0; k < W * H; k++) begin
      step(1'b1, 1'b0, DW'(100 + 10 * (k / W) + (k % W)), AW'(k % W));
      if (k == 6) begin
        chk("f2_t", {win_t0, win_t1, win_t2}, 0);
        chk("f2_m0", win_m0, 100); chk("f2_m1", win_m1, 101); chk("f2_m2", win_m2, 102);
      end
    end

    // Resync pulse at frame pixel 5.
    for (int k = 0; k < 5; k++) step(1'b1, k == 0, DW'($urandom), AW'($urandom));
    for (int k = 0; k < W * H; k++) begin
      step(1'b1, k == 0, DW'($urandom), AW'($urandom));
      if (k == 5) begin
        chk("sof_rc", {out_row, out_col}, 0);
        chk("sof_left", {win_t0, win_m0, win_b0}, 0);
        chk("sof_border", out_border, 1);
      end
    end

    // Random traffic with idle cycles and occasional resyncs.
    for (int k = 0; k < 400; k++) begin
      bit v;
      v = ($urandom_range(0, 3) != 0);
      step(v, v && ($urandom_range(0, 39) == 0), DW'($urandom), AW'($urandom));
    end

    // Asynchronous reset while a window is valid.
    for (int k = 0; k < 6; k++) step(1'b1, k == 0, DW'($urandom | 1), AW'($urandom));
    chk("pre_rst_valid", out_valid, 1);
    in_valid = 1'b0;
    in_sof = 1'b0;
    #1;
    rst = 1'b1;
    #1;
    check_zero("async_rst");
    @(posedge clk);
    #1;
    rst = 1'b0;
    mr = 0;
    mc = 0;
    frame_one(1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
